// File: rtl/alu_wide_ctrl_if.sv
// Request/result handshake bundle between a requester and the 16-bit ALU sequencer.
// The requester drives operands and accepts results; the sequencer answers.
interface alu_wide_ctrl_if;
  logic        start_valid;
  logic        start_ready;
  logic [1:0]  op;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [15:0] res;
  logic        res_c;
  logic        res_z;
  logic        res_valid;
  logic        res_ready;

  modport master (
    output start_valid, op, a_in, b_in, res_ready,
    input  start_ready, res, res_c, res_z, res_valid
  );

  modport slave (
    input  start_valid, op, a_in, b_in, res_ready,
    output start_ready, res, res_c, res_z, res_valid
  );
endinterface

// File: rtl/alu_wide_ctrl.sv
// Sequences a 16-bit ADD/SUB/AND/XOR through an external 8-bit ALU: low byte,
// high byte, then an optional high-byte increment/decrement to absorb the low carry.
module alu_wide_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  alu_wide_ctrl_if.slave  bus,
  output logic [3:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_out,
  input  logic [2:0]      alu_flags
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [1:0]  op_q;
  logic        c0;
  logic        c1;
  logic [15:0] res_q;
  logic        res_c_q;
  logic        res_valid_q;

  // Only the carry/borrow flag matters; the low operand bytes are consumed
  // straight from the request inputs when it is accepted.
  logic unused_ok;
  assign unused_ok = &{1'b0, alu_flags[1:0], a_q[7:0], b_q[7:0]};

  function automatic logic [3:0] map_op(input logic [1:0] o);
    case (o)
      2'b00:   map_op = 4'b0001;
      2'b01:   map_op = 4'b0010;
      2'b10:   map_op = 4'b0111;
      default: map_op = 4'b1001;
    endcase
  endfunction

  function automatic logic is_arith(input logic [1:0] o);
    is_arith = (o == 2'b00) || (o == 2'b01);
  endfunction

  assign bus.start_ready = (state == IDLE);
  assign bus.res         = res_q;
  assign bus.res_c       = res_c_q;
  assign bus.res_z       = (res_q == 16'h0000);
  assign bus.res_valid   = res_valid_q;

  // ALU drive is registered one state ahead so it is stable for the whole state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      c0          <= 1'b0;
      c1          <= 1'b0;
      res_q       <= '0;
      res_c_q     <= 1'b0;
      res_valid_q <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q    <= bus.a_in;
            b_q    <= bus.b_in;
            op_q   <= bus.op;
            alu_op <= map_op(bus.op);
            alu_a  <= bus.a_in[7:0];
            alu_b  <= bus.b_in[7:0];
            state  <= LO;
          end
        end

        LO: begin
          res_q[7:0] <= alu_out;
          c0         <= alu_flags[2];
          alu_a      <= a_q[15:8];
          alu_b      <= b_q[15:8];
          state      <= HI;
        end

        HI: begin
          res_q[15:8] <= alu_out;
          c1          <= alu_flags[2];
          if (is_arith(op_q) && c0) begin
            // Ripple the low-byte carry/borrow into the high byte with the same opcode.
            alu_a <= alu_out;
            alu_b <= 8'h01;
            state <= FIX;
          end else begin
            res_c_q     <= is_arith(op_q) ? alu_flags[2] : 1'b0;
            res_valid_q <= 1'b1;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            state       <= DONE;
          end
        end

        FIX: begin
          res_q[15:8] <= alu_out;
          res_c_q     <= c1 | alu_flags[2];
          res_valid_q <= 1'b1;
          alu_op      <= '0;
          alu_a       <= '0;
          alu_b       <= '0;
          state       <= DONE;
        end

        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          res_valid_q <= 1'b0;
          alu_op      <= '0;
          alu_a       <= '0;
          alu_b       <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
